// File: rtl/if_stage_if.sv
// Interface bundle between the fetch stage and its environment (hazard/branch control and imem).
interface if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if;
    logic [31:0] inst_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic        stall_timeout;

    // Drives stall/redirect and returns the instruction word.
    modport master (
        output stall, redirect_valid, redirect_target, imem_rdata,
        input  imem_addr, pc_if, inst_id, pc_plus4_id, valid_id,
        input  stall_cycles, flush_count, stall_timeout
    );

    // The fetch stage itself.
    modport slave (
        input  stall, redirect_valid, redirect_target, imem_rdata,
        output imem_addr, pc_if, inst_id, pc_plus4_id, valid_id,
        output stall_cycles, flush_count, stall_timeout
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, stall/flush statistics.
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_LIMIT = 8,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    if_stage_if.slave   bus
);
    localparam logic [3:0] LIMIT = 4'(STALL_LIMIT);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pp4_q, pp4_d;
    logic        vld_q, vld_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [3:0]  run_q, run_d;
    logic        tmo_q, tmo_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        pp4_d       = pp4_q;
        vld_d       = vld_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        run_d       = 4'd0;
        tmo_d       = tmo_q;
        if (bus.stall) begin
            // Redirect is dropped while stalled; ID re-presents it once the stall clears.
            if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
            run_d = (run_q == 4'hF) ? 4'hF : run_q + 4'd1;
            if (run_d == LIMIT) tmo_d = 1'b1;
        end else if (bus.redirect_valid) begin
            pc_d   = {bus.redirect_target[31:2], 2'b00};
            inst_d = NOP_INSTR;
            pp4_d  = 32'd0;
            vld_d  = 1'b0;
            if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            pc_d   = pc_plus4;
            inst_d = bus.imem_rdata;
            pp4_d  = pc_plus4;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INSTR;
            pp4_q       <= 32'd0;
            vld_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            run_q       <= 4'd0;
            tmo_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            pp4_q       <= pp4_d;
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.pc_if         = pc_q;
    assign bus.inst_id       = inst_q;
    assign bus.pc_plus4_id   = pp4_q;
    assign bus.valid_id      = vld_q;
    assign bus.stall_cycles  = stall_cnt_q;
    assign bus.flush_count   = flush_cnt_q;
    assign bus.stall_timeout = tmo_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirect, timeout, wrap and reset-during-stall.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0), .STALL_LIMIT(8), .NOP_INSTR(32'h0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0001 : {8'hA5, a[23:0]};
    endfunction

    assign bus.imem_rdata = mem(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] pp4, input logic vld);
        chk({tag, ".pc"}, bus.pc_if, pc);
        chk({tag, ".addr"}, bus.imem_addr, pc);
        chk({tag, ".inst"}, bus.inst_id, inst);
        chk({tag, ".pp4"}, bus.pc_plus4_id, pp4);
        chk({tag, ".vld"}, 32'(bus.valid_id), 32'(vld));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        @(negedge clk);
        step(2);
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.stc", 32'(bus.stall_cycles), 32'd0);
        chk("rst.flc", 32'(bus.flush_count), 32'd0);
        chk("rst.tmo", 32'(bus.stall_timeout), 32'd0);

        // Sequential fetch from reset
        rst_n = 1'b1;
        step(1);
        chk_ifid("f1", 32'h4, 32'h2008_0001, 32'h4, 1'b1);
        step(1);
        chk_ifid("f2", 32'h8, mem(32'h4), 32'h8, 1'b1);

        // Two-cycle stall at 0x8
        bus.stall = 1'b1;
        step(1);
        chk_ifid("s1", 32'h8, mem(32'h4), 32'h8, 1'b1);
        chk("s1.stc", 32'(bus.stall_cycles), 32'd1);
        step(1);
        chk_ifid("s2", 32'h8, mem(32'h4), 32'h8, 1'b1);
        chk("s2.stc", 32'(bus.stall_cycles), 32'd2);
        chk("s2.tmo", 32'(bus.stall_timeout), 32'd0);
        bus.stall = 1'b0;
        step(1);
        chk_ifid("r1", 32'hC, mem(32'h8), 32'hC, 1'b1);
        step(1);
        chk("r2.pc", bus.pc_if, 32'h10);

        // Redirect to 0x40, then misaligned 0x43
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h40;
        step(1);
        chk_ifid("rd1", 32'h40, 32'h0, 32'h0, 1'b0);
        chk("rd1.flc", 32'(bus.flush_count), 32'd1);
        bus.redirect_target = 32'h43;
        step(1);
        chk_ifid("rd2", 32'h40, 32'h0, 32'h0, 1'b0);
        chk("rd2.flc", 32'(bus.flush_count), 32'd2);
        bus.redirect_valid = 1'b0;
        step(1);
        chk_ifid("rd3", 32'h44, mem(32'h40), 32'h44, 1'b1);

        // Stall beats redirect
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h80;
        step(1);
        chk_ifid("sr1", 32'h44, mem(32'h40), 32'h44, 1'b1);
        chk("sr1.flc", 32'(bus.flush_count), 32'd2);
        chk("sr1.stc", 32'(bus.stall_cycles), 32'd3);
        bus.stall = 1'b0;
        step(1);
        chk_ifid("sr2", 32'h80, 32'h0, 32'h0, 1'b0);
        chk("sr2.flc", 32'(bus.flush_count), 32'd3);
        bus.redirect_valid = 1'b0;

        // Eight-cycle stall sets sticky timeout
        bus.stall = 1'b1;
        step(7);
        chk("to7.tmo", 32'(bus.stall_timeout), 32'd0);
        step(1);
        chk("to8.tmo", 32'(bus.stall_timeout), 32'd1);
        chk("to8.stc", 32'(bus.stall_cycles), 32'd11);
        chk_ifid("to8", 32'h80, 32'h0, 32'h0, 1'b0);
        bus.stall = 1'b0;
        step(1);
        chk("to9.tmo", 32'(bus.stall_timeout), 32'd1);
        chk_ifid("to9", 32'h84, mem(32'h80), 32'h84, 1'b1);

        // PC wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFE;
        step(1);
        chk("w1.pc", bus.pc_if, 32'hFFFF_FFFC);
        chk("w1.flc", 32'(bus.flush_count), 32'd4);
        bus.redirect_valid = 1'b0;
        step(1);
        chk_ifid("w2", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);
        chk("w2.tmo", 32'(bus.stall_timeout), 32'd1);

        // Reset during stall with redirect pending
        bus.stall = 1'b1;
        step(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h100;
        rst_n = 1'b0;
        step(1);
        chk_ifid("rs", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rs.stc", 32'(bus.stall_cycles), 32'd0);
        chk("rs.flc", 32'(bus.flush_count), 32'd0);
        chk("rs.tmo", 32'(bus.stall_timeout), 32'd0);
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        rst_n = 1'b1;
        step(1);
        chk_ifid("rs1", 32'h4, 32'h2008_0001, 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
